c_seq_gen_ff: RTL and testbench
===============================

# c_seq_gen_ff

Parametrised NR pseudo-random sequence generator (TS 38.211 §5.2.1 Gold sequence, Nc = 1600) with a load-time start offset and valid/ready output backpressure. On load it fast-forwards both LFSRs past Nc + offset bits using wide multi-bit steps, then streams nGenBit-wide words of c(n). The block feeds the PUCCH cyclic-shift hopping and scrambling consumers directly from the requested slot position, with no discarded output cycles downstream. It is the successor of the fixed-start, free-running c_seq_gen.

## Interface
Parameters:
- nGenBit, 8 — output bits per word; 1..32.
- nSkipBit, 64 — bits advanced per coarse warm-up cycle; ≥ nGenBit.
- OFFSET_W, 16 — width of i_offset.
- LEN_W, 12 — width of i_len.

Ports:
- clk  in  1  — single clock.
- rst  in  1  — reset, synchronous, active-high.
- i_load  in  1  — start/restart pulse; samples i_init, i_offset, i_len.
- i_init  in  31  — c_init.
- i_offset  in  OFFSET_W  — index n of the first output bit.
- i_len  in  LEN_W  — number of words to emit; 0 = unbounded.
- i_ready  in  1  — consumer accepts the current word.
- o_seq_bit  out  nGenBit  — c(n..n+nGenBit-1); MSB = c(n).
- o_valid  out  1  — o_seq_bit is valid.
- o_busy  out  1  — state ≠ IDLE.
- o_done  out  1  — 1-cycle pulse after the last word of a bounded run is accepted.

## Operation
- LFSR definition:
  - x1 is loaded as x1(0) = 1, x1(1..30) = 0.
  - x2 is loaded as x2(i) = i_init[i].
  - x1(n+31) = x1(n+3) ⊕ x1(n).
  - x2(n+31) = x2(n+3) ⊕ x2(n+2) ⊕ x2(n+1) ⊕ x2(n).
  - c(n) = x1(n+Nc) ⊕ x2(n+Nc).
- Warm-up distance: D = 1600 + i_offset, held in a 17+ bit down-counter.
- State IDLE:
  - Outputs are low.
  - i_ready is ignored.
  - i_load loads both LFSRs, sets the remaining count to D and the word count to i_len, then moves to COARSE.
- State COARSE:
  - While remaining ≥ nSkipBit: advance both LFSRs by nSkipBit bits and subtract nSkipBit.
  - Otherwise move to FINE.
- State FINE:
  - While remaining > 0: advance by 1 bit and decrement.
  - At 0, move to RUN.
- State RUN:
  - o_valid = 1 and o_seq_bit holds the current word.
  - On o_valid & i_ready: advance by nGenBit and decrement the word count.
  - If the accepted word was the last of a bounded run, pulse o_done and go to IDLE.
  - While o_valid & !i_ready, o_seq_bit and the LFSR state are held stable.
- i_load in any non-IDLE state aborts the run and restarts exactly as from IDLE. o_valid drops the next cycle.
- rst has priority over i_load.
- Multi-bit advances are combinational GF(2) jump functions: a k-step LFSR unroll at elaboration, with no runtime matrices.

## Timing
- Reset value of every output: o_seq_bit = 0, o_valid = 0, o_busy = 0, o_done = 0; state IDLE.
- i_load is sampled at edge T0. o_busy = 1 from T0+1.
- Warm-up cycles: W = ⌊D/nSkipBit⌋ + (D mod nSkipBit) + 1 (the +1 covers the FINE exit). o_valid first rises after edge T0+W.
- Example, nSkipBit = 64:
  - offset 0 → W = 26.
  - offset 336 → D = 1936 → W = 30 + 16 + 1 = 47.
- With i_ready held high, one word is produced per cycle.
- o_done rises the cycle after the final handshake. o_valid and o_busy are low in that same cycle.
- i_load coinciding with the final handshake: the restart wins and o_done is not pulsed.

## Structure
- Package c_seq_pkg contains:
  - NC = 1600.
  - X1_INIT = 31'h1.
  - The state typedef (IDLE, COARSE, FINE, RUN).
  - Tap functions for one x1 step and one x2 step.
- One sub-module, gold_lfsr_jump #(STEP, POLY_SEL): a combinational k-step advance of a 31-bit LFSR.
  - Instantiated for x1 and x2 at STEP = nSkipBit, nGenBit and 1.
- The top level holds the FSM, the counters and the output register.

## Test plan
Reference vectors come from Matlab nrPRBS.
1. nGenBit = 8, cinit = 512, offset = 0, len = 14, i_ready = 1 → o_valid first seen at T0+26. The 14 words match nrPRBS(512, 112), MSB first. o_done pulses once.
2. cinit = 512, offset = 336 (nslot = 3), len = 14 → o_valid at T0+47. Words equal nrPRBS bits 336..447.
3. cinit = 100, offset = 224, len = 14, i_ready pseudo-random at 50% → o_seq_bit stable while stalled. The accepted sequence equals the stall-free run exactly, with no skipped or duplicated words.
4. len = 0, cinit = 512; after 200 words, i_load with cinit = 100, offset = 0 → o_valid low the next cycle. The new stream matches nrPRBS(100) from bit 0 at T0+26, and no o_done occurs.
5. rst asserted mid-COARSE and again mid-RUN while stalled → all outputs 0 the next cycle, state IDLE. i_ready toggling in IDLE produces no o_valid.
6. nGenBit = 1, nSkipBit = 64 build, cases 1–2 repeated → serial bits match. Bits packed MSB-first give the same bytes as the nGenBit = 8 build.

Source files
------------

// File: rtl/c_seq_pkg.sv
// Shared constants, FSM state type and Gold-sequence LFSR taps
// for the offset-capable NR pseudo-random sequence generator.
package c_seq_pkg;

  localparam int NC = 1600;
  localparam logic [30:0] X1_INIT = 31'h1;

  typedef enum logic [1:0] {
    IDLE,
    COARSE,
    FINE,
    RUN
  } state_t;

  // Bit i of a state holds x(n+i); the feedback is x(n+31).
  function automatic logic x1_fb(input logic [30:0] s);
    return s[3] ^ s[0];
  endfunction

  function automatic logic x2_fb(input logic [30:0] s);
    return s[3] ^ s[2] ^ s[1] ^ s[0];
  endfunction

  function automatic logic [30:0] x1_step(input logic [30:0] s);
    return {x1_fb(s), s[30:1]};
  endfunction

  function automatic logic [30:0] x2_step(input logic [30:0] s);
    return {x2_fb(s), s[30:1]};
  endfunction

endpackage

// File: rtl/gold_lfsr_jump.sv
// Combinational STEP-bit advance of one 31-bit Gold LFSR,
// unrolled at elaboration (POLY_SEL 0 = x1, 1 = x2).
module gold_lfsr_jump
  import c_seq_pkg::*;
#(
  parameter int STEP     = 1,
  parameter int POLY_SEL = 0
) (
  input  logic [30:0] i_state,
  output logic [30:0] o_state
);

  always_comb begin
    o_state = i_state;
    for (int k = 0; k < STEP; k++) begin
      if (POLY_SEL == 0) o_state = x1_step(o_state);
      else               o_state = x2_step(o_state);
    end
  end

endmodule

// File: rtl/c_seq_gen_ff.sv
// NR Gold sequence generator: fast-forwards past Nc + offset,
// then streams nGenBit-wide words under valid/ready.
module c_seq_gen_ff
  import c_seq_pkg::*;
#(
  parameter int nGenBit  = 8,
  parameter int nSkipBit = 64,
  parameter int OFFSET_W = 16,
  parameter int LEN_W    = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic [30:0]         i_init,
  input  logic [OFFSET_W-1:0] i_offset,
  input  logic [LEN_W-1:0]    i_len,
  input  logic                i_ready,
  output logic [nGenBit-1:0]  o_seq_bit,
  output logic                o_valid,
  output logic                o_busy,
  output logic                o_done
);

  localparam int REM_W =
    ((OFFSET_W > 16) ? OFFSET_W : 16) + 1;
  localparam logic [REM_W-1:0] SKIP = REM_W'(nSkipBit);

  state_t             r_state, w_state;
  logic [30:0]        r_x1, r_x2, w_x1, w_x2;
  logic [REM_W-1:0]   r_rem, w_rem, w_rem_sub;
  logic [LEN_W-1:0]   r_words, w_words;
  logic               r_bounded, w_bounded;
  logic               r_done, w_done;
  logic               w_last;
  logic [30:0]        w_x1_skip, w_x2_skip;
  logic [30:0]        w_x1_gen, w_x2_gen;
  logic [30:0]        w_x1_one, w_x2_one;
  logic [nGenBit-1:0] w_word;

  gold_lfsr_jump #(.STEP(nSkipBit), .POLY_SEL(0)) u_x1_skip (
    .i_state(r_x1), .o_state(w_x1_skip));
  gold_lfsr_jump #(.STEP(nSkipBit), .POLY_SEL(1)) u_x2_skip (
    .i_state(r_x2), .o_state(w_x2_skip));
  gold_lfsr_jump #(.STEP(nGenBit), .POLY_SEL(0)) u_x1_gen (
    .i_state(r_x1), .o_state(w_x1_gen));
  gold_lfsr_jump #(.STEP(nGenBit), .POLY_SEL(1)) u_x2_gen (
    .i_state(r_x2), .o_state(w_x2_gen));
  gold_lfsr_jump #(.STEP(1), .POLY_SEL(0)) u_x1_one (
    .i_state(r_x1), .o_state(w_x1_one));
  gold_lfsr_jump #(.STEP(1), .POLY_SEL(1)) u_x2_one (
    .i_state(r_x2), .o_state(w_x2_one));

  assign w_rem_sub = r_rem - SKIP;
  assign w_last    = r_bounded && (r_words == LEN_W'(1));

  always_comb begin
    w_state   = r_state;
    w_x1      = r_x1;
    w_x2      = r_x2;
    w_rem     = r_rem;
    w_words   = r_words;
    w_bounded = r_bounded;
    w_done    = 1'b0;
    if (i_load) begin
      w_state   = COARSE;
      w_x1      = X1_INIT;
      w_x2      = i_init;
      w_rem     = REM_W'(NC) + REM_W'(i_offset);
      w_words   = i_len;
      w_bounded = |i_len;
    end else begin
      unique case (r_state)
        IDLE: ;
        COARSE: begin
          // Leave for FINE on the last coarse step to save a cycle.
          if (r_rem >= SKIP) begin
            w_x1  = w_x1_skip;
            w_x2  = w_x2_skip;
            w_rem = w_rem_sub;
            if (w_rem_sub < SKIP) w_state = FINE;
          end else begin
            w_state = FINE;
          end
        end
        FINE: begin
          if (r_rem != '0) begin
            w_x1  = w_x1_one;
            w_x2  = w_x2_one;
            w_rem = r_rem - REM_W'(1);
          end else begin
            w_state = RUN;
          end
        end
        RUN: begin
          if (i_ready) begin
            w_x1 = w_x1_gen;
            w_x2 = w_x2_gen;
            if (r_bounded) w_words = r_words - LEN_W'(1);
            if (w_last) begin
              w_state = IDLE;
              w_done  = 1'b1;
            end
          end
        end
        default: w_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_x1      <= '0;
      r_x2      <= '0;
      r_rem     <= '0;
      r_words   <= '0;
      r_bounded <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_x1      <= w_x1;
      r_x2      <= w_x2;
      r_rem     <= w_rem;
      r_words   <= w_words;
      r_bounded <= w_bounded;
      r_done    <= w_done;
    end
  end

  // Word bit k is c(n+k); bit 31 needs the next feedback bit.
  for (genvar k = 0; k < nGenBit; k++) begin : g_word
    if (k == 31) begin : g_fb
      assign w_word[nGenBit-1-k] = x1_fb(r_x1) ^ x2_fb(r_x2);
    end else begin : g_st
      assign w_word[nGenBit-1-k] = r_x1[k] ^ r_x2[k];
    end
  end

  assign o_valid   = (r_state == RUN);
  assign o_busy    = (r_state != IDLE);
  assign o_done    = r_done;
  assign o_seq_bit = o_valid ? w_word : '0;

endmodule

// File: tb/tb_c_seq_gen_ff.sv
// Bench for c_seq_gen_ff: byte-wide and serial builds checked
// against a bit-level Gold sequence model through scoreboards.
module tb_c_seq_gen_ff;

  localparam int NB = 2400;
  localparam int NCB = 1600;
  localparam int NUNB = 200;

  logic        clk = 1'b0;
  logic        rst, i_load, i_ready;
  logic [30:0] i_init;
  logic [15:0] i_offset;
  logic [11:0] len8, len1;
  logic [7:0]  seq8;
  logic        seq1;
  logic        v8, v1, b8, b1, d8, d1;

  always #5 clk = ~clk;

  c_seq_gen_ff #(.nGenBit(8), .nSkipBit(64),
    .OFFSET_W(16), .LEN_W(12)) u_dut8 (
    .clk(clk), .rst(rst), .i_load(i_load), .i_init(i_init),
    .i_offset(i_offset), .i_len(len8), .i_ready(i_ready),
    .o_seq_bit(seq8), .o_valid(v8), .o_busy(b8), .o_done(d8));

  c_seq_gen_ff #(.nGenBit(1), .nSkipBit(64),
    .OFFSET_W(16), .LEN_W(12)) u_dut1 (
    .clk(clk), .rst(rst), .i_load(i_load), .i_init(i_init),
    .i_offset(i_offset), .i_len(len1), .i_ready(i_ready),
    .o_seq_bit(seq1), .o_valid(v1), .o_busy(b1), .o_done(d1));

  int total = 0;
  int bad = 0;

  bit x1 [0:NB+NCB-1];
  bit x2 [0:NB+NCB-1];
  bit cref [0:NB-1];

  logic [7:0] q8[$];
  logic       q1[$];
  bit         bnd8, bnd1, expd8, expd1, stall8, stall1, rnd;
  logic [7:0] last8;
  logic       last1;
  int         dcnt8, dcnt1;

  typedef struct {
    logic [30:0] ci;
    int          off;
    int          len;
    bit          rnd;
    int          w;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  task automatic build_ref(input logic [30:0] ci);
    for (int i = 0; i < 31; i++) begin
      x1[i] = (i == 0);
      x2[i] = ci[i];
    end
    for (int n = 0; n + 31 < NB + NCB; n++) begin
      x1[n+31] = x1[n+3] ^ x1[n];
      x2[n+31] = x2[n+3] ^ x2[n+2] ^ x2[n+1] ^ x2[n];
    end
    for (int n = 0; n < NB; n++) cref[n] = x1[n+NCB] ^ x2[n+NCB];
  endtask

  task automatic do_load(input logic [30:0] ci, input int off,
                         input int l8, input int l1);
    int n8, n1;
    logic [7:0] w;
    build_ref(ci);
    i_init = ci;
    i_offset = 16'(off);
    len8 = 12'(l8);
    len1 = 12'(l1);
    i_load = 1'b1;
    q8.delete();
    q1.delete();
    bnd8 = (l8 != 0);
    bnd1 = (l1 != 0);
    dcnt8 = 0;
    dcnt1 = 0;
    n8 = bnd8 ? l8 : NUNB;
    n1 = bnd1 ? l1 : NUNB;
    for (int j = 0; j < n8; j++) begin
      for (int k = 0; k < 8; k++) w[7-k] = cref[off + 8*j + k];
      q8.push_back(w);
    end
    for (int j = 0; j < n1; j++) q1.push_back(cref[off + j]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd) i_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic start(input logic [30:0] ci, input int off,
                       input int l8, input int l1);
    do_load(ci, off, l8, l1);
    tick();
    i_load = 1'b0;
  endtask

  task automatic wait_valid(input int exp_w, input string nm);
    int cnt = 0;
    while (!v8 && cnt < 400) begin
      tick();
      cnt++;
      if (cnt == 1) chk({nm, "_busy"}, {30'd0, b8, b1}, 32'd3);
    end
    chk({nm, "_warmup"}, cnt, exp_w);
    chk({nm, "_valid1"}, v1, 1);
  endtask

  task automatic wait_end(input string nm);
    int cnt = 0;
    while ((q8.size() != 0 || q1.size() != 0 || b8 || b1)
           && cnt < 4000) begin
      tick();
      cnt++;
    end
    chk({nm, "_timeout"}, cnt < 4000, 1);
    tick();
    tick();
    chk({nm, "_done_cnt8"}, dcnt8, bnd8 ? 1 : 0);
    chk({nm, "_done_cnt1"}, dcnt1, bnd1 ? 1 : 0);
  endtask

  // Scoreboard and protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (expd8) begin
      chk("done8_cycle", {29'd0, d8, v8, b8}, 32'd4);
      expd8 = 1'b0;
    end else if (d8) begin
      chk("spurious_done8", d8, 0);
    end
    if (d8) dcnt8++;
    if (stall8 && v8) chk("stall_hold8", seq8, last8);
    stall8 = v8 && !i_ready && !i_load && !rst;
    last8 = seq8;
    if (v8 && i_ready && !i_load && !rst) begin
      if (q8.size() == 0) chk("extra_word8", 1, 0);
      else begin
        chk("word8", seq8, q8.pop_front());
        if (bnd8 && q8.size() == 0) expd8 = 1'b1;
      end
    end

    if (expd1) begin
      chk("done1_cycle", {29'd0, d1, v1, b1}, 32'd4);
      expd1 = 1'b0;
    end else if (d1) begin
      chk("spurious_done1", d1, 0);
    end
    if (d1) dcnt1++;
    if (stall1 && v1) chk("stall_hold1", seq1, last1);
    stall1 = v1 && !i_ready && !i_load && !rst;
    last1 = seq1;
    if (v1 && i_ready && !i_load && !rst) begin
      if (q1.size() == 0) chk("extra_word1", 1, 0);
      else begin
        chk("word1", seq1, q1.pop_front());
        if (bnd1 && q1.size() == 0) expd1 = 1'b1;
      end
    end
  end

  initial begin
    int cnt;
    rst = 1'b1;
    i_load = 1'b0;
    i_ready = 1'b0;
    i_init = '0;
    i_offset = '0;
    len8 = '0;
    len1 = '0;
    rnd = 1'b0;
    bnd8 = 1'b0;
    bnd1 = 1'b0;
    expd8 = 1'b0;
    expd1 = 1'b0;
    stall8 = 1'b0;
    stall1 = 1'b0;
    dcnt8 = 0;
    dcnt1 = 0;

    vt[0] = '{31'd512, 0, 14, 1'b0, 26};
    vt[1] = '{31'd512, 336, 14, 1'b0, 47};
    vt[2] = '{31'd100, 224, 14, 1'b1, 61};
    vt[3] = '{31'd7, 63, 5, 1'b0, 89};
    vt[4] = '{31'h7fffffff, 64, 3, 1'b1, 27};
    vt[5] = '{31'd1, 1, 1, 1'b0, 27};

    repeat (3) tick();
    chk("rst_out8", {seq8, v8, b8, d8}, 0);
    chk("rst_out1", {seq1, v1, b1, d1}, 0);
    rst = 1'b0;

    foreach (vt[i]) begin
      i_ready = 1'b1;
      rnd = vt[i].rnd;
      start(vt[i].ci, vt[i].off, vt[i].len, vt[i].len * 8);
      wait_valid(vt[i].w, "vec");
      wait_end("vec");
      rnd = 1'b0;
    end

    // Unbounded run, then restart on the fly.
    i_ready = 1'b1;
    start(31'd512, 0, 0, 0);
    wait_valid(26, "unb");
    cnt = 0;
    while (q8.size() != 0 && cnt < 1000) begin
      tick();
      cnt++;
    end
    chk("unb_timeout", cnt < 1000, 1);
    chk("unb_no_done", dcnt8 + dcnt1, 0);
    do_load(31'd100, 0, 14, 112);
    tick();
    i_load = 1'b0;
    chk("restart_valid_low", {v8, v1}, 0);
    wait_valid(26, "restart");
    wait_end("restart");

    // Restart coinciding with the final handshake suppresses done.
    start(31'd512, 0, 3, 0);
    wait_valid(26, "coin");
    tick();
    tick();
    do_load(31'd100, 5, 2, 16);
    tick();
    i_load = 1'b0;
    chk("coin_state8", {29'd0, d8, v8, b8}, 32'd1);
    wait_valid(31, "coin2");
    wait_end("coin2");

    // Reset mid-warm-up, together with a load.
    start(31'd512, 0, 14, 112);
    repeat (10) tick();
    rst = 1'b1;
    i_load = 1'b1;
    tick();
    chk("rst_coarse8", {seq8, v8, b8, d8}, 0);
    chk("rst_coarse1", {seq1, v1, b1, d1}, 0);
    rst = 1'b0;
    i_load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      i_ready = ~i_ready;
      tick();
      chk("idle_ready", {v8, v1, b8, b1}, 0);
    end

    // Reset while stalled in RUN.
    i_ready = 1'b1;
    start(31'd512, 0, 14, 112);
    wait_valid(26, "stall");
    i_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("rst_run8", {seq8, v8, b8, d8}, 0);
    chk("rst_run1", {seq1, v1, b1, d1}, 0);
    rst = 1'b0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
